// File: rtl/booth_multiplier.sv
// Sequential radix-2 Booth multiplier: one add/subtract-and-shift step per clock.
// Returns the low WIDTH bits of the signed product and a signed-overflow flag.
module booth_multiplier #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CW    = 6
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             ctrl_MULT,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  output logic [WIDTH-1:0] data_result,
  output logic             data_exception,
  output logic             data_resultRDY,
  output logic             busy
);

  localparam int unsigned PW = 2 * WIDTH + 2;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH:0]   m_q, m_d;
  logic [PW-1:0]    p_q, p_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             exc_q, exc_d;
  logic             rdy_q, busy_q;

  logic [WIDTH:0]   upper_c, sum_c, prod_hi_c;
  logic [PW-1:0]    p_add_c, p_shift_c;
  logic             exc_c;

  // One Booth step on the current partial product: add/sub M in the upper field, then arithmetic shift
  always_comb begin
    upper_c = p_q[PW-1:WIDTH+1];
    case (p_q[1:0])
      2'b01:   sum_c = upper_c + m_q;
      2'b10:   sum_c = upper_c + (~m_q + {{WIDTH{1'b0}}, 1'b1});
      default: sum_c = upper_c;
    endcase
    p_add_c   = {sum_c, p_q[WIDTH:0]};
    p_shift_c = {p_add_c[PW-1], p_add_c[PW-1:1]};
    // Product occupies P[2W:1]; it fits in WIDTH bits iff product[2W-1:W-1] is all-equal
    prod_hi_c = p_shift_c[2*WIDTH:WIDTH];
    exc_c     = ~((&prod_hi_c) | ~(|prod_hi_c));
  end

  // Next-state and datapath register updates
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    m_d     = m_q;
    p_d     = p_q;
    res_d   = res_q;
    exc_d   = exc_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (ctrl_MULT) begin
          m_d     = {data_operandA[WIDTH-1], data_operandA};
          p_d     = {{(WIDTH+1){1'b0}}, data_operandB, 1'b0};
          cnt_d   = '0;
          res_d   = '0;
          exc_d   = 1'b0;
          state_d = S_RUN;
        end else if (state_q == S_DONE) begin
          state_d = S_IDLE;
        end
      end
      S_RUN: begin
        p_d   = p_shift_c;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH - 1)) begin
          res_d   = p_shift_c[WIDTH:1];
          exc_d   = exc_c;
          state_d = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers; status flags registered from the next state
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      m_q     <= '0;
      p_q     <= '0;
      res_q   <= '0;
      exc_q   <= 1'b0;
      rdy_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      m_q     <= m_d;
      p_q     <= p_d;
      res_q   <= res_d;
      exc_q   <= exc_d;
      rdy_q   <= (state_d == S_DONE);
      busy_q  <= (state_d == S_RUN);
    end
  end

  assign data_result    = res_q;
  assign data_exception = exc_q;
  assign data_resultRDY = rdy_q;
  assign busy           = busy_q;

endmodule

// File: tb/tb_booth_multiplier.sv
// Self-checking bench for booth_multiplier against a plain 64-bit signed product model.
module tb_booth_multiplier;

  localparam int unsigned W = 32;

  logic         clock;
  logic         reset_n;
  logic         ctrl_MULT;
  logic [W-1:0] data_operandA;
  logic [W-1:0] data_operandB;
  logic [W-1:0] data_result;
  logic         data_exception;
  logic         data_resultRDY;
  logic         busy;

  int checks = 0;
  int errors = 0;

  booth_multiplier #(.WIDTH(32), .CW(6)) dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .ctrl_MULT      (ctrl_MULT),
    .data_operandA  (data_operandA),
    .data_operandB  (data_operandB),
    .data_result    (data_result),
    .data_exception (data_exception),
    .data_resultRDY (data_resultRDY),
    .busy           (busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: exact signed product, low word, and representability in W bits
  task automatic model(input logic [W-1:0] a, input logic [W-1:0] b,
                       output logic [W-1:0] res, output logic exc);
    longint p;
    longint lo_sext;
    p       = longint'($signed(a)) * longint'($signed(b));
    res     = p[W-1:0];
    lo_sext = longint'($signed(res));
    exc     = (p != lo_sext);
  endtask

  // Present operands with a one-cycle start pulse; returns just after accepting edge k
  task automatic start(input logic [W-1:0] a, input logic [W-1:0] b);
    data_operandA = a;
    data_operandB = b;
    ctrl_MULT     = 1'b1;
    @(posedge clock);
    #1;
    ctrl_MULT = 1'b0;
    check("start_busy", 64'(busy), 64'(1'b1));
    check("start_clr_res", 64'(data_result), 64'd0);
  endtask

  // Walk edges k+1..k+W; optionally pulse a (to-be-ignored) start before edge k+pulse_at
  task automatic wait_result(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                             input int pulse_at);
    logic [W-1:0] er;
    logic         ee;
    int           bad;
    model(a, b, er, ee);
    bad = 0;
    for (int i = 1; i <= int'(W); i++) begin
      if (i == pulse_at) begin
        data_operandA = 32'd7;
        data_operandB = 32'd7;
        ctrl_MULT     = 1'b1;
      end
      @(posedge clock);
      #1;
      ctrl_MULT = 1'b0;
      if (i < int'(W) && (data_resultRDY !== 1'b0 || busy !== 1'b1)) bad++;
    end
    check({tag, "_run_flags"}, 64'(bad), 64'd0);
    check({tag, "_rdy"}, 64'(data_resultRDY), 64'(1'b1));
    check({tag, "_busy_done"}, 64'(busy), 64'(1'b0));
    check({tag, "_res"}, 64'(data_result), 64'(er));
    check({tag, "_exc"}, 64'(data_exception), 64'(ee));
  endtask

  // After a DONE cycle with no restart: pulse ends, result holds
  task automatic idle_after(input string tag, input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0] er;
    logic         ee;
    model(a, b, er, ee);
    @(posedge clock);
    #1;
    check({tag, "_rdy_drop"}, 64'(data_resultRDY), 64'(1'b0));
    check({tag, "_hold"}, {31'd0, data_exception, data_result}, {31'd0, ee, er});
  endtask

  task automatic full_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b);
    start(a, b);
    wait_result(tag, a, b, 0);
    idle_after(tag, a, b);
  endtask

  initial begin
    logic [W-1:0] ra, rb;
    int           bad;
    reset_n       = 1'b0;
    ctrl_MULT     = 1'b0;
    data_operandA = '0;
    data_operandB = '0;
    #1;
    check("rst_res", 64'(data_result), 64'd0);
    check("rst_flags", {61'd0, data_exception, data_resultRDY, busy}, 64'd0);
    repeat (2) @(posedge clock);
    #1;
    reset_n = 1'b1;
    @(posedge clock);
    #1;

    // Directed cases from the multiplier's corner points
    full_op("basic",    32'd6,          32'hFFFF_FFFE);
    full_op("ovf_pos",  32'h7FFF_FFFF,  32'd2);
    full_op("ovf_min",  32'h8000_0000,  32'hFFFF_FFFF);
    full_op("min_x1",   32'h8000_0000,  32'd1);
    full_op("zero_min", 32'd0,          32'h8000_0000);
    full_op("neg1sq",   32'hFFFF_FFFF,  32'hFFFF_FFFF);
    full_op("min_sq",   32'h8000_0000,  32'h8000_0000);

    // Start during RUN is ignored
    start(32'd3, 32'd5);
    wait_result("ign", 32'd3, 32'd5, 10);
    idle_after("ign", 32'd3, 32'd5);

    // Reset in the middle of an operation
    start(32'd100, 32'd100);
    repeat (15) @(posedge clock);
    #1;
    reset_n = 1'b0;
    #1;
    check("midrst_out", {30'd0, data_exception, data_resultRDY, busy, data_result}, 64'd0);
    bad = 0;
    repeat (3) begin
      @(posedge clock);
      #1;
      if (data_resultRDY !== 1'b0 || busy !== 1'b0) bad++;
    end
    check("midrst_hold", 64'(bad), 64'd0);
    reset_n = 1'b1;
    bad = 0;
    repeat (W + 4) begin
      @(posedge clock);
      #1;
      if (data_resultRDY !== 1'b0) bad++;
    end
    check("midrst_no_rdy", 64'(bad), 64'd0);
    full_op("post_rst", 32'd9, 32'hFFFF_FFF7);

    // Back-to-back: restart during the DONE cycle
    start(32'd11, 32'd13);
    wait_result("b2b_a", 32'd11, 32'd13, 0);
    start(32'hFFFF_FFF9, 32'd6);
    check("b2b_rdy_drop", 64'(data_resultRDY), 64'(1'b0));
    wait_result("b2b_b", 32'hFFFF_FFF9, 32'd6, 0);
    idle_after("b2b_b", 32'hFFFF_FFF9, 32'd6);

    // Randomized operands, some biased toward small magnitudes and extremes
    for (int n = 0; n < 24; n++) begin
      ra = $urandom;
      rb = $urandom;
      case (n % 4)
        1: rb = 32'($signed(rb[7:0]));
        2: ra = 32'($signed(ra[15:0]));
        3: begin ra = {ra[31], {31{~ra[31]}}}; rb = 32'($signed(rb[3:0])); end
        default: ;
      endcase
      full_op("rand", ra, rb);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
